// File: rtl/cei_mochila_pkg.sv
// ----------------------------------------------------------------------------
// cei_mochila_pkg
// Mochila accelerator shared types and constants.
//   bridge_state_e             : external slave bridge operating state
//   EXT_BRIDGE_*               : default parameters of mochila_ext_slave_bridge
//   bridge_cnt_w()             : bit width needed to hold 0..max_val (min 1)
// ----------------------------------------------------------------------------
package cei_mochila_pkg;

  typedef enum logic [1:0] {
    BRIDGE_NORMAL   = 2'd0,
    BRIDGE_FLUSH    = 2'd1,
    BRIDGE_ISOLATED = 2'd2
  } bridge_state_e;

  localparam int unsigned EXT_BRIDGE_MAX_OUTSTANDING = 32'd2;
  localparam int unsigned EXT_BRIDGE_TIMEOUT_CYCLES  = 32'd1024;
  localparam logic [31:0] EXT_BRIDGE_TIMEOUT_RDATA   = 32'hDEAD_BEEF;

  // Width of a counter that must reach max_val; a zero max still gets one bit.
  function automatic int unsigned bridge_cnt_w(input int unsigned max_val);
    if (max_val < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage : cei_mochila_pkg

// File: rtl/obi_pkg.sv
// ----------------------------------------------------------------------------
// obi_pkg
// OBI request/response bundles shared by the Mochila bus blocks.
//   obi_req_t  : req, we, be, addr, wdata   (manager -> subordinate)
//   obi_resp_t : gnt, rvalid, rdata          (subordinate -> manager)
// ----------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage : obi_pkg

// File: rtl/mochila_ext_slave_bridge_checker.sv
// ----------------------------------------------------------------------------
// mochila_ext_slave_bridge_checker
// Simulation properties for the external slave bridge.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   normal_i       : bridge is in NORMAL
//   rvalid_i       : host response valid
//   dn_zero_i      : no transaction is outstanding at the host
//   owed_ok_i      : owed count is within MAX_OUTSTANDING
// ----------------------------------------------------------------------------
module mochila_ext_slave_bridge_checker (
  input logic clk_i,
  input logic rst_ni,
  input logic normal_i,
  input logic rvalid_i,
  input logic dn_zero_i,
  input logic owed_ok_i
);

  // A host response with nothing outstanding is a protocol error (it is dropped).
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(normal_i && rvalid_i && dn_zero_i));

  a_owed_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni) owed_ok_i);

endmodule : mochila_ext_slave_bridge_checker

// File: rtl/mochila_obi_req_slice.sv
// ----------------------------------------------------------------------------
// mochila_obi_req_slice
// Single-entry OBI request register with valid/ready handshakes on both sides.
// The entry can be dropped with flush_i without a downstream handshake.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : discard the held entry at the next edge
//   in_valid_i     : upstream offers in_req_i
//   in_req_i       : request fields to capture
//   in_ready_o     : slice can accept this cycle (empty, or draining now)
//   out_valid_o    : an entry is held
//   out_req_o      : held request fields (stable while out_ready_i is low)
//   out_ready_i    : downstream takes the held entry this cycle
// ----------------------------------------------------------------------------
module mochila_obi_req_slice
  import obi_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  logic     in_valid_i,
  input  obi_req_t in_req_i,
  output logic     in_ready_o,
  output logic     out_valid_o,
  output obi_req_t out_req_o,
  input  logic     out_ready_i
);

  logic     valid_r;
  obi_req_t data_r;

  assign in_ready_o  = ~valid_r | out_ready_i;
  assign out_valid_o = valid_r;
  assign out_req_o   = data_r;

  // Entry register: flush wins, then load on accept, then drain on downstream take.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_r <= 1'b1;
      data_r  <= in_req_i;
    end else if (out_ready_i) begin
      valid_r <= 1'b0;
    end
  end

endmodule : mochila_obi_req_slice

// File: rtl/mochila_ext_slave_bridge.sv
// ----------------------------------------------------------------------------
// mochila_ext_slave_bridge
// Bridge between the Mochila external OBI slave port and the host bus. Registers
// requests (through a one-entry slice) and responses, bounds the number of owed
// transactions, and runs a response watchdog. On expiry it flushes every owed
// response locally with TIMEOUT_RDATA and then isolates the accelerator from the
// host until clear_i.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   slv_req_i      : request from the accelerator
//   slv_resp_o     : gnt (combinational), rvalid/rdata (registered)
//   mst_req_o      : request to the host bus (slice contents)
//   mst_resp_i     : response from the host bus
//   clear_i        : pulse, leaves ISOLATED
//   timeout_o      : high while not NORMAL
//   outstanding_o  : transactions granted upstream but not yet answered upstream
// ----------------------------------------------------------------------------
module mochila_ext_slave_bridge
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = EXT_BRIDGE_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = EXT_BRIDGE_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA   = EXT_BRIDGE_TIMEOUT_RDATA,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 32'd1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         slv_req_i,
  output obi_resp_t        slv_resp_o,
  output obi_req_t         mst_req_o,
  input  obi_resp_t        mst_resp_i,
  input  logic             clear_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] outstanding_o
);

  localparam int unsigned WD_W = bridge_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [WD_W-1:0]  WD_ZERO  = WD_W'(32'd0);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(32'd1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  bridge_state_e    state_r;
  logic [CNT_W-1:0] owed_r;       // granted upstream, not yet answered upstream
  logic [CNT_W-1:0] dn_r;         // handed to the host, not yet answered by it
  logic [WD_W-1:0]  wd_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;

  logic             st_normal_s, st_flush_s, st_isolated_s;
  logic             slice_ready_s, slice_valid_s, slice_in_valid_s, slice_out_ready_s;
  obi_req_t         slice_req_s;
  logic             real_rv_s, synth_s, owed_dec_s, dn_dec_s, room_s;
  logic             slv_gnt_s, up_hs_s, slice_hs_s, fire_s;
  logic [CNT_W-1:0] owed_nxt_s, dn_nxt_s;
  logic [WD_W-1:0]  wd_nxt_s;
  logic             rsp_valid_nxt_s;
  logic [31:0]      rsp_rdata_nxt_s;

  assign st_normal_s   = (state_r == BRIDGE_NORMAL);
  assign st_flush_s    = (state_r == BRIDGE_FLUSH);
  assign st_isolated_s = (state_r == BRIDGE_ISOLATED);

  // A host response only counts if something is outstanding there; in FLUSH it
  // has priority over the synthetic response of that cycle.
  assign real_rv_s  = mst_resp_i.rvalid && !st_isolated_s && (dn_r != CNT_ZERO);
  assign synth_s    = st_flush_s && !real_rv_s && (owed_r != CNT_ZERO);
  assign owed_dec_s = real_rv_s || synth_s;
  // Synthetic answers retire the oldest owed entries, which are the host ones.
  assign dn_dec_s   = real_rv_s || (synth_s && (dn_r != CNT_ZERO));
  assign room_s     = (owed_r < CNT_MAX) || owed_dec_s;

  assign slv_gnt_s         = slv_req_i.req && !st_flush_s && room_s && slice_ready_s;
  assign up_hs_s           = slv_gnt_s && st_normal_s;
  assign slice_in_valid_s  = slv_req_i.req && st_normal_s && room_s;
  assign slice_out_ready_s = mst_resp_i.gnt && st_normal_s;
  assign slice_hs_s        = slice_valid_s && slice_out_ready_s;

  assign fire_s = st_normal_s && (TIMEOUT_CYCLES != 32'd0) && !mst_resp_i.rvalid
                  && (owed_r != CNT_ZERO) && (wd_r == WD_LIMIT);

  mochila_obi_req_slice u_req_slice (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (st_flush_s),
    .in_valid_i  (slice_in_valid_s),
    .in_req_i    (slv_req_i),
    .in_ready_o  (slice_ready_s),
    .out_valid_o (slice_valid_s),
    .out_req_o   (slice_req_s),
    .out_ready_i (slice_out_ready_s)
  );

  // Owed/downstream counter updates; simultaneous increment and decrement cancel.
  always_comb begin
    owed_nxt_s = owed_r;
    if (up_hs_s && !owed_dec_s) begin
      owed_nxt_s = owed_r + CNT_ONE;
    end else if (!up_hs_s && owed_dec_s) begin
      owed_nxt_s = owed_r - CNT_ONE;
    end else begin
      owed_nxt_s = owed_r;
    end

    dn_nxt_s = dn_r;
    if (slice_hs_s && !dn_dec_s) begin
      dn_nxt_s = dn_r + CNT_ONE;
    end else if (!slice_hs_s && dn_dec_s) begin
      dn_nxt_s = dn_r - CNT_ONE;
    end else begin
      dn_nxt_s = dn_r;
    end
  end

  // Watchdog: counts NORMAL cycles with owed work and no host response, saturating.
  always_comb begin
    wd_nxt_s = wd_r;
    if (!st_normal_s || (TIMEOUT_CYCLES == 32'd0) || mst_resp_i.rvalid || (owed_r == CNT_ZERO)) begin
      wd_nxt_s = WD_ZERO;
    end else if (wd_r == WD_LIMIT) begin
      wd_nxt_s = wd_r;
    end else begin
      wd_nxt_s = wd_r + WD_ONE;
    end
  end

  // Upstream response source: local answer when isolated, else host data, else synthetic.
  always_comb begin
    rsp_valid_nxt_s = 1'b0;
    rsp_rdata_nxt_s = rsp_rdata_r;
    if (st_isolated_s) begin
      rsp_valid_nxt_s = slv_gnt_s;
      rsp_rdata_nxt_s = TIMEOUT_RDATA;
    end else if (real_rv_s) begin
      rsp_valid_nxt_s = 1'b1;
      rsp_rdata_nxt_s = mst_resp_i.rdata;
    end else if (synth_s) begin
      rsp_valid_nxt_s = 1'b1;
      rsp_rdata_nxt_s = TIMEOUT_RDATA;
    end else begin
      rsp_valid_nxt_s = 1'b0;
      rsp_rdata_nxt_s = rsp_rdata_r;
    end
  end

  // Bridge FSM together with its counters and the registered upstream response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= BRIDGE_NORMAL;
      owed_r      <= CNT_ZERO;
      dn_r        <= CNT_ZERO;
      wd_r        <= WD_ZERO;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      owed_r      <= owed_nxt_s;
      dn_r        <= dn_nxt_s;
      wd_r        <= wd_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      case (state_r)
        BRIDGE_NORMAL: begin
          if (fire_s) state_r <= BRIDGE_FLUSH;
        end
        BRIDGE_FLUSH: begin
          if (owed_r == CNT_ZERO) state_r <= BRIDGE_ISOLATED;
        end
        BRIDGE_ISOLATED: begin
          if (clear_i) begin
            state_r <= BRIDGE_NORMAL;
            owed_r  <= CNT_ZERO;
            dn_r    <= CNT_ZERO;
            wd_r    <= WD_ZERO;
          end
        end
        default: state_r <= BRIDGE_NORMAL;
      endcase
    end
  end

  // Host request is the slice entry, withdrawn the moment the bridge leaves NORMAL.
  always_comb begin
    mst_req_o     = slice_req_s;
    mst_req_o.req = slice_valid_s && st_normal_s;
  end

  // Upstream response bundle.
  always_comb begin
    slv_resp_o        = '0;
    slv_resp_o.gnt    = slv_gnt_s;
    slv_resp_o.rvalid = rsp_valid_r;
    slv_resp_o.rdata  = rsp_rdata_r;
  end

  assign timeout_o     = !st_normal_s;
  assign outstanding_o = owed_r;

  mochila_ext_slave_bridge_checker u_checker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .normal_i  (st_normal_s),
    .rvalid_i  (mst_resp_i.rvalid),
    .dn_zero_i (dn_r == CNT_ZERO),
    .owed_ok_i (owed_r <= CNT_MAX)
  );

endmodule : mochila_ext_slave_bridge
